snoop_dispatch: RTL

Round-robin dispatcher that shares one packet snooper among `N` parallel packetfilter cores. It sits above the per-core ping/pang/pong buffer controllers in the parallel-cores wrapper.

---
 rtl/snoop_dispatch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/snoop_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : snoop_dispatch
// Purpose  : Round-robin dispatcher that shares one packet snooper among N
//            packetfilter cores. For each packet it picks a core with a free
//            snooper-side buffer, claims it, grants the snooper and relays
//            the snooper's completion back to that core.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            rdy_for_A[N]        - core has a free snooper-side buffer
//            rdy_for_A_ack[N]    - one-hot, one-cycle buffer claim
//            A_done[N]           - one-hot done, held until A_done_ack
//            A_done_ack[N]       - core accepts the done indication
//            sn_req / sn_gnt     - snooper request / access grant (levels)
//            sn_core[SEL_W]      - index of the claimed core
//            sn_done             - one-cycle snooper completion pulse
//            pkt_cnt[32]         - completed dispatches, wraps
// Revision : 1.0 - initial release
// ============================================================================
module snoop_dispatch #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     rdy_for_A,
  output logic [N-1:0]     rdy_for_A_ack,
  output logic [N-1:0]     A_done,
  input  logic [N-1:0]     A_done_ack,
  input  logic             sn_req,
  output logic             sn_gnt,
  output logic [SEL_W-1:0] sn_core,
  input  logic             sn_done,
  output logic [31:0]      pkt_cnt
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CLAIM = 2'd1;
  localparam logic [1:0] c_GRANT = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [N-1:0]     c_ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] c_LAST = SEL_W'(N - 1);
  localparam logic [SEL_W:0]   c_NUM  = (SEL_W + 1)'(N);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [SEL_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0] w_scan_sel;
  logic             w_scan_hit;
  logic [SEL_W:0]   w_idx;
  logic             w_pkt_fin;
  logic [N-1:0]     w_ack_nxt;
  logic [N-1:0]     w_done_nxt;
  logic             w_gnt_nxt;

  // Round-robin scan: first ready core at or after rr_ptr, modulo N.
  // The index is one bit wider so rr_ptr+k cannot overflow before the wrap.
  always_comb begin
    w_scan_sel = '0;
    w_scan_hit = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (SEL_W + 1)'(k);
      if (w_idx >= c_NUM) begin
        w_idx = w_idx - c_NUM;
      end
      if (!w_scan_hit && rdy_for_A[w_idx[SEL_W-1:0]]) begin
        w_scan_hit = 1'b1;
        w_scan_sel = w_idx[SEL_W-1:0];
      end
    end
  end

  // The packet completes when the chosen core (and only that core) acks.
  assign w_pkt_fin = (r_state == c_DONE) && A_done_ack[r_sel];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_sel    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      if (w_pkt_fin) begin
        r_rr_ptr <= (r_sel == c_LAST) ? '0 : r_sel + 1'b1;
      end
    end
  end

  // Next-state logic; sel is frozen once chosen so later rdy_for_A changes
  // cannot move the claim to another core.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    case (r_state)
      c_IDLE: begin
        if (sn_req && w_scan_hit) begin
          w_state_nxt = c_CLAIM;
          w_sel_nxt   = w_scan_sel;
        end
      end
      c_CLAIM: w_state_nxt = c_GRANT;
      c_GRANT: begin
        if (sn_done) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE: begin
        if (w_pkt_fin) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output logic, decoded from the next state so that every output can be
  // registered and still line up with the state it belongs to.
  always_comb begin
    w_ack_nxt  = '0;
    w_done_nxt = '0;
    w_gnt_nxt  = 1'b0;
    case (w_state_nxt)
      c_CLAIM: w_ack_nxt  = c_ONE << w_sel_nxt;
      c_GRANT: w_gnt_nxt  = 1'b1;
      c_DONE:  w_done_nxt = c_ONE << w_sel_nxt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_for_A_ack <= '0;
      A_done        <= '0;
      sn_gnt        <= 1'b0;
      sn_core       <= '0;
      pkt_cnt       <= '0;
    end else begin
      rdy_for_A_ack <= w_ack_nxt;
      A_done        <= w_done_nxt;
      sn_gnt        <= w_gnt_nxt;
      sn_core       <= w_sel_nxt;
      if (w_pkt_fin) begin
        pkt_cnt <= pkt_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire
